// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller: bypass selects, cache FSM encodings, clog2.
// No logic; imported by hazard_ctrl_p and hazard_fwd_cmp.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } dstate_e;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_MISS = 2'd1,
    I_DROP = 2'd2
  } istate_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Source/destination match: hit when the producer writes a nonzero register equal to src.
// Purely combinational, no handshake.
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] dst,
  input  logic            we,
  output logic            hit
);

  assign hit = we && (dst != '0) && (dst == src);

endmodule

// File: rtl/hazard_ctrl_p.sv
// Hazard/forwarding controller for the 5-stage pipeline; enables are same-cycle combinational.
// Optional per-cause stall counters under HAZARD_STALL_CNT_EN.
module hazard_ctrl_p
  import hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 32
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ID_RS,
  input  logic [RA_W-1:0] ID_RT,
  input  logic            ID_RSUse,
  input  logic            ID_RTUse,
  input  logic            ID_HiLoUse,
  input  logic            BJOp,
  input  logic [RA_W-1:0] EX_RS,
  input  logic [RA_W-1:0] EX_RT,
  input  logic [RA_W-1:0] EX_RD,
  input  logic            EX_RFWr,
  input  logic            EX_LdUse,
  input  logic [RA_W-1:0] MEM_RD,
  input  logic            MEM_RFWr,
  input  logic            MEM_LdUse,
  input  logic [RA_W-1:0] WB_RD,
  input  logic            WB_RFWr,
  input  logic            md_start,
  input  logic            MEM_ex,
  input  logic            MEM_eret_flush,
  input  logic            MEM_dreq,
  input  logic            dCache_data_ok,
  input  logic            if_req,
  input  logic            iCache_data_ok,
  output logic [1:0]      FwdA,
  output logic [1:0]      FwdB,
  output logic            BrFwdA,
  output logic            BrFwdB,
  output logic            PCWr,
  output logic            IF_IDWr,
  output logic            ID_EXBubble,
  output logic            EX_MEMWr,
  output logic            MEM_WBWr,
  output logic            IF_IDFlush,
  output logic            pipe_flush,
  output logic            isStall
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] load_stall_cnt
  , output logic [CNT_W-1:0] br_stall_cnt
  , output logic [CNT_W-1:0] md_stall_cnt
  , output logic [CNT_W-1:0] dc_stall_cnt
  , output logic [CNT_W-1:0] ic_stall_cnt
`endif
);

  localparam int              MD_W    = clog2(MD_LAT + 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);

  logic mem_a, wb_a, mem_b, wb_b, ex_s, ex_t, me_s, me_t;

  hazard_fwd_cmp #(.RA_W(RA_W)) u_mem_a (.src(EX_RS), .dst(MEM_RD), .we(MEM_RFWr), .hit(mem_a));
  hazard_fwd_cmp #(.RA_W(RA_W)) u_wb_a  (.src(EX_RS), .dst(WB_RD),  .we(WB_RFWr),  .hit(wb_a));
  hazard_fwd_cmp #(.RA_W(RA_W)) u_mem_b (.src(EX_RT), .dst(MEM_RD), .we(MEM_RFWr), .hit(mem_b));
  hazard_fwd_cmp #(.RA_W(RA_W)) u_wb_b  (.src(EX_RT), .dst(WB_RD),  .we(WB_RFWr),  .hit(wb_b));
  hazard_fwd_cmp #(.RA_W(RA_W)) u_ex_s  (.src(ID_RS), .dst(EX_RD),  .we(EX_RFWr),  .hit(ex_s));
  hazard_fwd_cmp #(.RA_W(RA_W)) u_ex_t  (.src(ID_RT), .dst(EX_RD),  .we(EX_RFWr),  .hit(ex_t));
  hazard_fwd_cmp #(.RA_W(RA_W)) u_me_s  (.src(ID_RS), .dst(MEM_RD), .we(MEM_RFWr), .hit(me_s));
  hazard_fwd_cmp #(.RA_W(RA_W)) u_me_t  (.src(ID_RT), .dst(MEM_RD), .we(MEM_RFWr), .hit(me_t));

  assign FwdA   = mem_a ? FWD_MEM : (wb_a ? FWD_WB : FWD_RF);
  assign FwdB   = mem_b ? FWD_MEM : (wb_b ? FWD_WB : FWD_RF);
  assign BrFwdA = BJOp & ~MEM_LdUse & me_s;
  assign BrFwdB = BJOp & ~MEM_LdUse & me_t;

  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  dstate_e         d_q, d_d;
  istate_e         i_q, i_d;

  logic id_ex_use, id_mem_use, il_load, il_br, il_md, interlock;
  logic redirect, dfreeze, ihold;

  assign id_ex_use  = (ex_s & ID_RSUse) | (ex_t & ID_RTUse);
  assign id_mem_use = (me_s & ID_RSUse) | (me_t & ID_RTUse);
  assign il_load    = EX_LdUse & id_ex_use;
  assign il_br      = BJOp & (id_ex_use | (MEM_LdUse & id_mem_use));
  assign il_md      = ID_HiLoUse & (md_cnt_q != '0);
  assign interlock  = il_load | il_br | il_md;

  // A redirect kills the MEM instruction, so its D-cache request must not freeze anything.
  assign redirect = MEM_ex | MEM_eret_flush;
  assign dfreeze  = MEM_dreq & ~dCache_data_ok & ~redirect;
  assign ihold    = (i_q == I_DROP) | (~iCache_data_ok & ((i_q == I_MISS) | if_req));

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start && (md_cnt_q == '0)) md_cnt_d = MD_LOAD;
    else if (md_cnt_q != '0)          md_cnt_d = md_cnt_q - 1'b1;

    d_d = d_q;
    case (d_q)
      D_IDLE:  if (dfreeze) d_d = D_BUSY;
      D_BUSY:  if (dCache_data_ok) d_d = D_IDLE;
      default: d_d = D_IDLE;
    endcase

    i_d = i_q;
    case (i_q)
      I_IDLE: if (if_req && !iCache_data_ok) i_d = I_MISS;
      I_MISS: begin
        if (iCache_data_ok) i_d = I_IDLE;
        else if (redirect)  i_d = I_DROP;
      end
      I_DROP:  if (iCache_data_ok) i_d = I_IDLE;
      default: i_d = I_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q <= '0;
      d_q      <= D_IDLE;
      i_q      <= I_IDLE;
    end else begin
      md_cnt_q <= md_cnt_d;
      d_q      <= d_d;
      i_q      <= i_d;
    end
  end

  always_comb begin
    PCWr        = 1'b1;
    IF_IDWr     = 1'b1;
    ID_EXBubble = 1'b0;
    EX_MEMWr    = 1'b1;
    MEM_WBWr    = 1'b1;
    pipe_flush  = 1'b0;
    IF_IDFlush  = 1'b0;
    if (rst) begin
      PCWr        = 1'b0;
      IF_IDWr     = 1'b0;
      ID_EXBubble = 1'b1;
    end else begin
      // The wrong-path fetch finally returning is thrown away while the front end stays held.
      IF_IDFlush = (i_q == I_DROP) & iCache_data_ok;
      if (redirect) begin
        pipe_flush  = 1'b1;
        ID_EXBubble = 1'b1;
      end else if (dfreeze) begin
        PCWr     = 1'b0;
        IF_IDWr  = 1'b0;
        EX_MEMWr = 1'b0;
        MEM_WBWr = 1'b0;
      end else if (ihold || interlock) begin
        PCWr        = 1'b0;
        IF_IDWr     = 1'b0;
        ID_EXBubble = 1'b1;
      end
    end
  end

  assign isStall = ~PCWr | dfreeze;

`ifdef HAZARD_STALL_CNT_EN
  logic [4:0]            win;
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  fe_ok;

  assign fe_ok  = ~rst & ~redirect & ~dfreeze & ~ihold;
  assign win[0] = fe_ok & il_load;
  assign win[1] = fe_ok & ~il_load & il_br;
  assign win[2] = fe_ok & ~il_load & ~il_br & il_md;
  assign win[3] = ~rst & ~redirect & dfreeze;
  assign win[4] = ~rst & ~redirect & ~dfreeze & ihold;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 5; k++) begin
      if (win[k] && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign load_stall_cnt = cnt_q[0];
  assign br_stall_cnt   = cnt_q[1];
  assign md_stall_cnt   = cnt_q[2];
  assign dc_stall_cnt   = cnt_q[3];
  assign ic_stall_cnt   = cnt_q[4];
`endif

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p: vector table for combinational cases, hand sequences for FSM/counter cases.
module tb_hazard_ctrl_p;
  import hazard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ID_RS, ID_RT, EX_RS, EX_RT, EX_RD, MEM_RD, WB_RD;
  logic       ID_RSUse, ID_RTUse, ID_HiLoUse, BJOp, EX_RFWr, EX_LdUse;
  logic       MEM_RFWr, MEM_LdUse, WB_RFWr, md_start, MEM_ex, MEM_eret_flush;
  logic       MEM_dreq, dCache_data_ok, if_req, iCache_data_ok;
  logic [1:0] FwdA, FwdB;
  logic       BrFwdA, BrFwdB, PCWr, IF_IDWr, ID_EXBubble, EX_MEMWr, MEM_WBWr;
  logic       IF_IDFlush, pipe_flush, isStall;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] c_ld, c_br, c_md, c_dc, c_ic;
`endif

  hazard_ctrl_p #(.RA_W(5), .MD_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_RSUse(ID_RSUse), .ID_RTUse(ID_RTUse),
    .ID_HiLoUse(ID_HiLoUse), .BJOp(BJOp),
    .EX_RS(EX_RS), .EX_RT(EX_RT), .EX_RD(EX_RD), .EX_RFWr(EX_RFWr), .EX_LdUse(EX_LdUse),
    .MEM_RD(MEM_RD), .MEM_RFWr(MEM_RFWr), .MEM_LdUse(MEM_LdUse),
    .WB_RD(WB_RD), .WB_RFWr(WB_RFWr), .md_start(md_start),
    .MEM_ex(MEM_ex), .MEM_eret_flush(MEM_eret_flush),
    .MEM_dreq(MEM_dreq), .dCache_data_ok(dCache_data_ok),
    .if_req(if_req), .iCache_data_ok(iCache_data_ok),
    .FwdA(FwdA), .FwdB(FwdB), .BrFwdA(BrFwdA), .BrFwdB(BrFwdB),
    .PCWr(PCWr), .IF_IDWr(IF_IDWr), .ID_EXBubble(ID_EXBubble),
    .EX_MEMWr(EX_MEMWr), .MEM_WBWr(MEM_WBWr), .IF_IDFlush(IF_IDFlush),
    .pipe_flush(pipe_flush), .isStall(isStall)
`ifdef HAZARD_STALL_CNT_EN
    , .load_stall_cnt(c_ld), .br_stall_cnt(c_br), .md_stall_cnt(c_md)
    , .dc_stall_cnt(c_dc), .ic_stall_cnt(c_ic)
`endif
  );

  typedef struct packed {
    logic [4:0]  id_rs, id_rt;
    logic        id_rsuse, id_rtuse, hilo, bjop;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_we, ex_ld;
    logic [4:0]  mem_rd;
    logic        mem_we, mem_ld;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        mex, meret, dreq, dok;
    logic [12:0] exp;
  } vec_t;

  // {PCWr, IF_IDWr, ID_EXBubble, EX_MEMWr, MEM_WBWr, pipe_flush, isStall}
  localparam logic [6:0] RUN  = 7'b1101100;
  localparam logic [6:0] HOLD = 7'b0011101;
  localparam logic [6:0] FRZ  = 7'b0000001;
  localparam logic [6:0] RDR  = 7'b1111110;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t b;
    b     = '0;
    b.dok = 1'b1;
    return b;
  endfunction

  task automatic apply(input vec_t v);
    ID_RS = v.id_rs; ID_RT = v.id_rt; ID_RSUse = v.id_rsuse; ID_RTUse = v.id_rtuse;
    ID_HiLoUse = v.hilo; BJOp = v.bjop;
    EX_RS = v.ex_rs; EX_RT = v.ex_rt; EX_RD = v.ex_rd; EX_RFWr = v.ex_we; EX_LdUse = v.ex_ld;
    MEM_RD = v.mem_rd; MEM_RFWr = v.mem_we; MEM_LdUse = v.mem_ld;
    WB_RD = v.wb_rd; WB_RFWr = v.wb_we;
    MEM_ex = v.mex; MEM_eret_flush = v.meret; MEM_dreq = v.dreq; dCache_data_ok = v.dok;
    md_start = 1'b0; if_req = 1'b0; iCache_data_ok = 1'b1; rst = 1'b0;
  endtask

  function automatic logic [12:0] outs();
    return {FwdA, FwdB, BrFwdA, BrFwdB, PCWr, IF_IDWr, ID_EXBubble, EX_MEMWr, MEM_WBWr,
            pipe_flush, isStall};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    v = blank(); v.ex_rs = 8; v.mem_rd = 8; v.mem_we = 1; v.wb_rd = 8; v.wb_we = 1;
    v.exp = {2'b01, 2'b00, 2'b00, RUN}; tbl.push_back(v);
    v.mem_rd = 0; v.exp = {2'b10, 2'b00, 2'b00, RUN}; tbl.push_back(v);
    v = blank(); v.ex_rs = 3; v.ex_rt = 8; v.mem_rd = 8; v.mem_we = 1; v.wb_rd = 3; v.wb_we = 1;
    v.exp = {2'b10, 2'b01, 2'b00, RUN}; tbl.push_back(v);
    v = blank(); v.ex_rs = 5; v.wb_rd = 5; v.exp = {2'b00, 2'b00, 2'b00, RUN}; tbl.push_back(v);
    v = blank(); v.mem_we = 1; v.wb_we = 1; v.ex_we = 1; v.ex_ld = 1; v.id_rsuse = 1;
    v.exp = {2'b00, 2'b00, 2'b00, RUN}; tbl.push_back(v);
    v = blank(); v.ex_ld = 1; v.ex_we = 1; v.ex_rd = 9; v.id_rt = 9; v.id_rtuse = 1;
    v.exp = {6'b0, HOLD}; tbl.push_back(v);
    v.id_rtuse = 0; v.exp = {6'b0, RUN}; tbl.push_back(v);
    v = blank(); v.ex_ld = 1; v.ex_rd = 9; v.id_rs = 9; v.id_rsuse = 1;
    v.exp = {6'b0, RUN}; tbl.push_back(v);
    v = blank(); v.bjop = 1; v.ex_we = 1; v.ex_rd = 7; v.id_rs = 7; v.id_rsuse = 1;
    v.exp = {6'b0, HOLD}; tbl.push_back(v);
    v.bjop = 0; v.exp = {6'b0, RUN}; tbl.push_back(v);
    v = blank(); v.bjop = 1; v.mem_we = 1; v.mem_rd = 6; v.id_rs = 6; v.id_rt = 6;
    v.id_rsuse = 1; v.id_rtuse = 1; v.exp = {2'b00, 2'b00, 2'b11, RUN}; tbl.push_back(v);
    v.mem_ld = 1; v.exp = {6'b0, HOLD}; tbl.push_back(v);
    v.id_rsuse = 0; v.id_rtuse = 0; v.exp = {6'b0, RUN}; tbl.push_back(v);
    v = blank(); v.mem_we = 1; v.mem_rd = 6; v.id_rs = 6; v.id_rsuse = 1;
    v.exp = {6'b0, RUN}; tbl.push_back(v);
    v = blank(); v.dreq = 1; v.dok = 0; v.exp = {6'b0, FRZ}; tbl.push_back(v);
    v.ex_ld = 1; v.ex_we = 1; v.ex_rd = 9; v.id_rt = 9; v.id_rtuse = 1;
    v.exp = {6'b0, FRZ}; tbl.push_back(v);
    v.mex = 1; v.exp = {6'b0, RDR}; tbl.push_back(v);
    v = blank(); v.meret = 1; v.exp = {6'b0, RDR}; tbl.push_back(v);
    v = blank(); v.dreq = 1; v.exp = {6'b0, RUN}; tbl.push_back(v);

    // Reset dominates a concurrent redirect, freeze and mul/div start.
    apply(blank());
    rst = 1'b1; MEM_ex = 1'b1; MEM_dreq = 1'b1; dCache_data_ok = 1'b0; md_start = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_ctrl", 16'(outs() & 13'h7f), 16'(HOLD));
    chk("reset_ififlush", 16'(IF_IDFlush), 16'd0);
    tick();
    apply(blank()); ID_HiLoUse = 1'b1;
    @(negedge clk);
    chk("reset_md_cnt", 16'(PCWr), 16'd1);
    chk("reset_dstate", 16'(dut.d_q), 16'(D_IDLE));
    chk("reset_istate", 16'(dut.i_q), 16'(I_IDLE));

    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 16'(outs()), 16'(tbl[i].exp));
    end

    // Mul/div occupancy: four held cycles, released on the fifth.
    tick(); apply(blank()); md_start = 1'b1;
    tick(); md_start = 1'b0; ID_HiLoUse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("md_pcwr%0d", i), 16'(PCWr), (i < 4) ? 16'd0 : 16'd1);
      chk($sformatf("md_bub%0d", i), 16'(ID_EXBubble), (i < 4) ? 16'd1 : 16'd0);
      tick();
    end
    ID_HiLoUse = 1'b0;

    // D-cache miss held three cycles.
    MEM_dreq = 1'b1; dCache_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("dc_frz%0d", i), 16'({EX_MEMWr, MEM_WBWr, PCWr, ID_EXBubble, isStall}), 16'b00001);
      if (i > 0) chk($sformatf("dc_busy%0d", i), 16'(dut.d_q), 16'(D_BUSY));
      tick();
    end
    dCache_data_ok = 1'b1;
    @(negedge clk);
    chk("dc_release", 16'({EX_MEMWr, MEM_WBWr, PCWr, ID_EXBubble}), 16'b1110);
    tick(); MEM_dreq = 1'b0;
    @(negedge clk);
    chk("dc_idle", 16'(dut.d_q), 16'(D_IDLE));

    // I-cache miss redirected in its second cycle, then the stale return is dropped.
    tick(); apply(blank()); if_req = 1'b1; iCache_data_ok = 1'b0;
    @(negedge clk);
    chk("ic_miss_hold", 16'({PCWr, IF_IDWr}), 16'b00);
    tick(); MEM_ex = 1'b1;
    @(negedge clk);
    chk("ic_miss_state", 16'(dut.i_q), 16'(I_MISS));
    chk("ic_redirect", 16'({pipe_flush, PCWr, IF_IDWr}), 16'b111);
    tick(); MEM_ex = 1'b0;
    @(negedge clk);
    chk("ic_drop_state", 16'(dut.i_q), 16'(I_DROP));
    chk("ic_drop_hold", 16'({PCWr, IF_IDFlush}), 16'b00);
    tick(); iCache_data_ok = 1'b1;
    @(negedge clk);
    chk("ic_drop_flush", 16'({IF_IDFlush, IF_IDWr}), 16'b10);
    tick();
    @(negedge clk);
    chk("ic_back_idle", 16'(dut.i_q), 16'(I_IDLE));
    chk("ic_next_fetch", 16'({IF_IDFlush, IF_IDWr}), 16'b01);

    // Reset while dropping: the late return must not flush anything.
    tick(); iCache_data_ok = 1'b0;
    tick(); MEM_ex = 1'b1;
    tick(); MEM_ex = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_pre", 16'(dut.i_q), 16'(I_DROP));
    tick(); rst = 1'b0; if_req = 1'b0; iCache_data_ok = 1'b1;
    @(negedge clk);
    chk("rst_drop_state", 16'(dut.i_q), 16'(I_IDLE));
    chk("rst_drop_late", 16'({IF_IDFlush, IF_IDWr, PCWr}), 16'b011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
